// File: rtl/ysyx_23060077_imem_rsp.sv
// Instruction-memory responder: serves INCR read bursts from an internal word array.
// Latency: first beat is the (LATENCY+1)-th cycle after the accept edge, then back-to-back beats.
// Backpressure: none; the initiator must take every beat, and request inputs are ignored outside IDLE.
//
// Ports:
//   clk, reset                          rising-edge clock, synchronous active-high reset
//   ifu_r_valid_i/addr_i/len_i          read request (len = beats-1), sampled only in IDLE
//   ifu_r_ready_o/data_o/last_o/err_o   registered beat outputs, active only in BEAT
//   mem_w_en_i/addr_i/data_i            preload write port, usable in any state
// Optional feature: define YSYX_23060077_IMEM_RAND_DELAY_EN to add 0-7 pseudo-random
// WAIT cycles (4-bit LFSR, x^4+x^3+1) before the first beat and between beats.
module ysyx_23060077_imem_rsp #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_r_valid_i,
  input  logic [31:0] ifu_r_addr_i,
  input  logic [7:0]  ifu_r_len_i,
  output logic        ifu_r_ready_o,
  output logic [31:0] ifu_r_data_o,
  output logic        ifu_r_last_o,
  output logic        ifu_r_err_o,
  input  logic        mem_w_en_i,
  input  logic [31:0] mem_w_addr_i,
  input  logic [31:0] mem_w_data_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, TURN} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_idx_q;
  logic [31:0] rd_addr_q;   // address of the next beat to be issued
  logic [31:0] mem [DEPTH];

  logic [31:0] rd_word, wr_word;
  logic        rd_in_range, wr_in_range;
  logic [2:0]  extra;       // extra WAIT cycles to insert at the next decision point

  // Word index math is 32-bit so an address below BASE_ADDR wraps to a huge index;
  // the explicit lower-bound test keeps that case out of range regardless.
  assign rd_word     = (rd_addr_q - BASE_ADDR) >> 2;
  assign rd_in_range = (rd_addr_q >= BASE_ADDR) && (rd_word < 32'(DEPTH));
  assign wr_word     = (mem_w_addr_i - BASE_ADDR) >> 2;
  assign wr_in_range = (mem_w_addr_i >= BASE_ADDR) && (wr_word < 32'(DEPTH));

`ifdef YSYX_23060077_IMEM_RAND_DELAY_EN
  logic [3:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 4'h1;
    else       lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  assign extra = lfsr_q[2:0];
`else
  assign extra = 3'd0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ifu_r_valid_i) state_d = WAIT;
      WAIT: if (cnt_q == 16'd0) state_d = BEAT;
      BEAT: begin
        if (ifu_r_last_o)       state_d = TURN;
        else if (extra != 3'd0) state_d = WAIT;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 16'd0;
      len_q         <= 8'd0;
      beat_idx_q    <= 8'd0;
      rd_addr_q     <= 32'd0;
      ifu_r_ready_o <= 1'b0;
      ifu_r_data_o  <= 32'd0;
      ifu_r_last_o  <= 1'b0;
      ifu_r_err_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ifu_r_ready_o <= 1'b0;
      ifu_r_data_o  <= 32'd0;
      ifu_r_last_o  <= 1'b0;
      ifu_r_err_o   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (ifu_r_valid_i) begin
            rd_addr_q  <= ifu_r_addr_i;
            len_q      <= ifu_r_len_i;
            beat_idx_q <= 8'd0;
            cnt_q      <= 16'(LATENCY - 1) + {13'd0, extra};
          end
        end
        WAIT: if (cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
        BEAT: begin
          // Gap before a non-final beat: k extra cycles means WAIT entered with k-1.
          if (!ifu_r_last_o && extra != 3'd0) cnt_q <= {13'd0, extra} - 16'd1;
        end
        default: ;
      endcase

      // Every edge that lands in BEAT issues exactly one beat, so outputs stay
      // aligned with the state and the array read is registered.
      if (state_d == BEAT) begin
        ifu_r_ready_o <= 1'b1;
        ifu_r_data_o  <= rd_in_range ? mem[rd_word[AW-1:0]] : 32'd0;
        ifu_r_err_o   <= !rd_in_range;
        ifu_r_last_o  <= (beat_idx_q == len_q);
        rd_addr_q     <= rd_addr_q + 32'd4;
        beat_idx_q    <= beat_idx_q + 8'd1;
      end
    end
  end

  // Array is not reset. Non-blocking update gives read-before-write on a same-edge collision.
  always_ff @(posedge clk) begin
    if (mem_w_en_i && wr_in_range) mem[wr_word[AW-1:0]] <= mem_w_data_i;
  end

endmodule

// File: tb/tb_ysyx_23060077_imem_rsp.sv
// Directed bench for ysyx_23060077_imem_rsp: table of single-beat reads plus
// hand-written bursts, range edges, held valid, read-before-write and mid-burst reset.
module tb_ysyx_23060077_imem_rsp;

  localparam int LAT = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [7:0]  len = 8'd0;
  logic        ready, last, err;
  logic [31:0] data;
  logic        w_en = 1'b0;
  logic [31:0] w_addr = 32'd0;
  logic [31:0] w_data = 32'd0;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] got_data [16];
  logic        got_err  [16];
  logic        got_last [16];
  int          got_k    [16];
  int          nbeats;
  logic        seen_last;
  logic        turn_rdy;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
  } vec_t;
  vec_t vt [7];

  ysyx_23060077_imem_rsp #(.BASE_ADDR(BASE), .DEPTH(1024), .LATENCY(LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .ifu_r_valid_i (valid),
    .ifu_r_addr_i  (addr),
    .ifu_r_len_i   (len),
    .ifu_r_ready_o (ready),
    .ifu_r_data_o  (data),
    .ifu_r_last_o  (last),
    .ifu_r_err_o   (err),
    .mem_w_en_i    (w_en),
    .mem_w_addr_i  (w_addr),
    .mem_w_data_i  (w_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    w_en = 1'b1; w_addr = a; w_data = d;
    @(posedge clk); #1;
    w_en = 1'b0;
  endtask

  // One idle edge, then accept edge E0; k counts edges after E0 (sampled #1 later).
  // drop: release valid and scramble addr/len right after accept (must be ignored).
  // wk: assert a write so that it is active at edge wk.
  task automatic run_req(input logic [31:0] a, input logic [7:0] l, input bit drop,
                         input int wk, input logic [31:0] wa, input logic [31:0] wd);
    int k;
    nbeats = 0; seen_last = 1'b0; turn_rdy = 1'b0; k = 0;
    @(posedge clk); #1;
    addr = a; len = l; valid = 1'b1;
    @(posedge clk); #1;
    if (drop) begin
      valid = 1'b0; addr = BASE + 32'h40; len = 8'd5;
    end
    while (!seen_last && k < 40) begin
      k++;
      if (k == wk) begin w_en = 1'b1; w_addr = wa; w_data = wd; end
      @(posedge clk); #1;
      w_en = 1'b0;
      if (ready === 1'b1) begin
        if (nbeats < 16) begin
          got_data[nbeats] = data; got_err[nbeats] = err;
          got_last[nbeats] = last; got_k[nbeats] = k;
        end
        nbeats++;
        if (last === 1'b1) begin
          seen_last = 1'b1;
          valid = 1'b0;
        end
      end
    end
    check("burst completes before budget", {31'd0, seen_last}, 32'd1);
    @(posedge clk); #1;
    turn_rdy = ready;
    check("no beat in TURN", {31'd0, turn_rdy}, 32'd0);
  endtask

  initial begin
    vt[0] = '{a: 32'h3000_0000, d: 32'h0000_0413, e: 1'b0};
    vt[1] = '{a: 32'h3000_0012, d: 32'h0000_00A0, e: 1'b0};
    vt[2] = '{a: 32'h3000_0FFC, d: 32'hDEAD_BEEF, e: 1'b0};
    vt[3] = '{a: 32'h3000_1000, d: 32'h0000_0000, e: 1'b1};
    vt[4] = '{a: 32'h2FFF_FFFC, d: 32'h0000_0000, e: 1'b1};
    vt[5] = '{a: 32'h0000_0000, d: 32'h0000_0000, e: 1'b1};
    vt[6] = '{a: 32'hFFFF_FFFC, d: 32'h0000_0000, e: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {31'd0, ready}, 32'd0);
    check("reset last",  {31'd0, last},  32'd0);
    check("reset err",   {31'd0, err},   32'd0);
    check("reset data",  data,           32'd0);
    reset = 1'b0;

    // Preload; the two out-of-range writes would alias words 0 and 1023 if not dropped.
    wr(BASE + 32'h0,   32'h0000_0413);
    wr(BASE + 32'h10,  32'h0000_00A0);
    wr(BASE + 32'h14,  32'h0000_00A1);
    wr(BASE + 32'h18,  32'h0000_00A2);
    wr(BASE + 32'h1C,  32'h0000_00A3);
    wr(BASE + 32'h20,  32'h1111_1111);
    wr(BASE + 32'h24,  32'h9999_9999);
    wr(BASE + 32'hFFC, 32'hDEAD_BEEF);
    wr(32'h3000_1000,  32'hBAD0_BAD0);
    wr(32'h2FFF_FFFC,  32'hBAD1_BAD1);

    // Single-beat table
    for (int i = 0; i < 7; i++) begin
      run_req(vt[i].a, 8'd0, 1'b0, 0, 32'd0, 32'd0);
      check($sformatf("vec%0d beats", i), nbeats, 1);
      check($sformatf("vec%0d data", i), got_data[0], vt[i].d);
      check($sformatf("vec%0d err", i), {31'd0, got_err[0]}, {31'd0, vt[i].e});
      check($sformatf("vec%0d last", i), {31'd0, got_last[0]}, 32'd1);
      check($sformatf("vec%0d latency", i), got_k[0], LAT);
    end

    // Four-beat burst, valid dropped and addr/len scrambled after accept
    run_req(BASE + 32'h10, 8'd3, 1'b1, 0, 32'd0, 32'd0);
    check("burst4 beats", nbeats, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst4 data%0d", i), got_data[i], 32'hA0 + 32'(i));
      check($sformatf("burst4 k%0d", i), got_k[i], LAT + i);
      check($sformatf("burst4 last%0d", i), {31'd0, got_last[i]}, (i == 3) ? 32'd1 : 32'd0);
    end

    // Burst crossing the lower bound
    run_req(32'h2FFF_FFFC, 8'd1, 1'b0, 0, 32'd0, 32'd0);
    check("low beats", nbeats, 2);
    check("low data0", got_data[0], 32'd0);
    check("low err0", {31'd0, got_err[0]}, 32'd1);
    check("low data1", got_data[1], 32'h0000_0413);
    check("low err1", {31'd0, got_err[1]}, 32'd0);
    check("low last1", {31'd0, got_last[1]}, 32'd1);

    // Burst crossing the upper bound
    run_req(BASE + 32'hFFC, 8'd1, 1'b0, 0, 32'd0, 32'd0);
    check("high beats", nbeats, 2);
    check("high data0", got_data[0], 32'hDEAD_BEEF);
    check("high last0", {31'd0, got_last[0]}, 32'd0);
    check("high data1", got_data[1], 32'd0);
    check("high err1", {31'd0, got_err[1]}, 32'd1);
    check("high last1", {31'd0, got_last[1]}, 32'd1);

    // Write lands on the same edge that reads word 8: old data comes back, new data afterwards
    run_req(BASE + 32'h20, 8'd1, 1'b0, LAT, BASE + 32'h20, 32'h2222_2222);
    check("rbw old data", got_data[0], 32'h1111_1111);
    check("rbw next word", got_data[1], 32'h9999_9999);
    run_req(BASE + 32'h20, 8'd0, 1'b0, 0, 32'd0, 32'd0);
    check("rbw new data", got_data[0], 32'h2222_2222);

    // Valid held high with len 0: beats every LAT+3 cycles (BEAT, TURN, IDLE, WAIT...)
    begin
      int cnt;
      int ks [4];
      cnt = 0;
      @(posedge clk); #1;
      addr = BASE; len = 8'd0; valid = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= LAT + 2 * (LAT + 3); k++) begin
        @(posedge clk); #1;
        if (ready === 1'b1) begin
          if (cnt < 4) ks[cnt] = k;
          cnt++;
          check($sformatf("held data k%0d", k), data, 32'h0000_0413);
        end
      end
      valid = 1'b0;
      check("held beat count", cnt, 3);
      for (int i = 0; i < 3 && i < cnt; i++)
        check($sformatf("held beat%0d k", i), ks[i], LAT + i * (LAT + 3));
      repeat (4) @(posedge clk);
      #1;
    end

    // Reset during the second beat of a four-beat burst
    begin
      int late;
      late = 0;
      addr = BASE + 32'h10; len = 8'd3; valid = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= LAT + 1; k++) begin
        @(posedge clk); #1;
      end
      check("pre-reset beat2 ready", {31'd0, ready}, 32'd1);
      check("pre-reset beat2 data", data, 32'h0000_00A1);
      reset = 1'b1; valid = 1'b0;
      @(posedge clk); #1;
      check("reset-edge ready", {31'd0, ready}, 32'd0);
      check("reset-edge data", data, 32'd0);
      check("reset-edge last", {31'd0, last}, 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (ready === 1'b1) late++;
      end
      check("beats after reset", late, 0);
      run_req(BASE, 8'd0, 1'b0, 0, 32'd0, 32'd0);
      check("post-reset beats", nbeats, 1);
      check("post-reset data", got_data[0], 32'h0000_0413);
      check("post-reset latency", got_k[0], LAT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
